// File: rtl/dsc_pkg.sv
// Shared types and defaults for the path output side (walker capture + forward emission).
//   estado_emissor_t : emitter FSM states
//   ADDR_WIDTH_DEF   : default node address width (64 nodes)
//   MAX_CAMINHO_DEF  : default maximum path length in nodes
package dsc_pkg;

  localparam int unsigned ADDR_WIDTH_DEF  = 6;
  localparam int unsigned MAX_CAMINHO_DEF = 64;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CAPTURA = 2'd1,
    EMITE   = 2'd2
  } estado_emissor_t;

endpackage

// File: rtl/emissor_caminho_pilha.sv
// pilha_lifo: flop-array LIFO holding one captured path.
//   clk, rst        : clock, synchronous active-high reset
//   clr             : empty the stack (wins over push/pop)
//   push, din       : write din on top; dropped when cheia
//   pop             : discard top entry; ignored when vazia
//   ptr             : number of stored entries
//   cheia, vazia    : full / empty flags
//   topo, sob_topo  : entry at ptr-1 and ptr-2 (0 when absent)
module pilha_lifo
  import dsc_pkg::*;
#(
  parameter int unsigned  ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned  DEPTH      = MAX_CAMINHO_DEF,
  localparam int unsigned PTR_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] din,
  output logic [PTR_WIDTH-1:0]  ptr,
  output logic                  cheia,
  output logic                  vazia,
  output logic [ADDR_WIDTH-1:0] topo,
  output logic [ADDR_WIDTH-1:0] sob_topo
);

  localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  ptr_q;
  logic                  wr_en;

  assign ptr   = ptr_q;
  assign cheia = (ptr_q == PTR_WIDTH'(DEPTH));
  assign vazia = (ptr_q == '0);
  assign wr_en = push && !cheia && !clr;

  // Reads are guarded so an empty or single-entry stack never indexes past the array.
  assign topo     = vazia ? '0 : mem[IDX_WIDTH'(ptr_q - PTR_WIDTH'(1))];
  assign sob_topo = (ptr_q < PTR_WIDTH'(2)) ? '0 : mem[IDX_WIDTH'(ptr_q - PTR_WIDTH'(2))];

  // Storage: no reset needed, contents are only read below ptr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[IDX_WIDTH'(ptr_q)] <= din;
    end
  end

  // Stack pointer.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr_q <= '0;
    end else if (wr_en) begin
      ptr_q <= ptr_q + PTR_WIDTH'(1);
    end else if (pop && !vazia) begin
      ptr_q <= ptr_q - PTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/emissor_caminho.sv
// emissor_caminho: captures the walker's destino-first address stream into a LIFO, then
// emits it fonte-first on a valid/ready stream with a last flag.
//   clk, rst        : clock, synchronous active-high reset
//   cap_inicio_in   : new request; starts/restarts capture, aborts emission
//   cap_valid_in    : one path address on cap_addr_in
//   cap_fim_in      : walker finished
//   out_valid/ready : output handshake; out_addr fonte-first, out_last marks destino
//   comprimento_out : stored path length, latched at cap_fim_in
//   ocupado_out     : block not idle
//   overflow_out    : sticky, capture exceeded MAX_CAMINHO
module emissor_caminho
  import dsc_pkg::*;
#(
  parameter int unsigned  ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned  MAX_CAMINHO = MAX_CAMINHO_DEF,
  localparam int unsigned PTR_WIDTH   = $clog2(MAX_CAMINHO + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_inicio_in,
  input  logic                  cap_valid_in,
  input  logic [ADDR_WIDTH-1:0] cap_addr_in,
  input  logic                  cap_fim_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic [PTR_WIDTH-1:0]  comprimento_out,
  output logic                  ocupado_out,
  output logic                  overflow_out
);

  estado_emissor_t       estado, estado_n;
  logic                  clr, push, pop;
  logic [PTR_WIDTH-1:0]  ptr;
  logic                  cheia, vazia;
  logic [ADDR_WIDTH-1:0] topo, sob_topo;
  logic                  overflow_n, valid_n, last_n;
  logic [PTR_WIDTH-1:0]  comp_n, comp_cap;
  logic [ADDR_WIDTH-1:0] addr_n;

  pilha_lifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (MAX_CAMINHO)
  ) u_pilha (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push     (push),
    .pop      (pop),
    .din      (cap_addr_in),
    .ptr      (ptr),
    .cheia    (cheia),
    .vazia    (vazia),
    .topo     (topo),
    .sob_topo (sob_topo)
  );

  // Next state, stack controls and next registered outputs.
  always_comb begin
    estado_n   = estado;
    clr        = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    overflow_n = overflow_out;
    comp_n     = comprimento_out;
    comp_cap   = ptr;
    valid_n    = 1'b0;
    addr_n     = '0;
    last_n     = 1'b0;

    case (estado)
      OCIOSO: begin
        if (cap_inicio_in) begin
          estado_n   = CAPTURA;
          clr        = 1'b1;
          overflow_n = 1'b0;
          comp_n     = '0;
        end
      end

      CAPTURA: begin
        if (cap_inicio_in) begin
          clr        = 1'b1;
          overflow_n = 1'b0;
          comp_n     = '0;
        end else begin
          if (cap_valid_in) begin
            if (cheia) begin
              overflow_n = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
          // A push in the fim cycle counts towards the length and is the first beat.
          comp_cap = ptr + PTR_WIDTH'(push);
          if (cap_fim_in) begin
            if (overflow_n || (comp_cap == '0)) begin
              estado_n = OCIOSO;
            end else begin
              estado_n = EMITE;
              comp_n   = comp_cap;
              valid_n  = 1'b1;
              addr_n   = push ? cap_addr_in : topo;
              last_n   = (comp_cap == PTR_WIDTH'(1));
            end
          end
        end
      end

      EMITE: begin
        if (cap_inicio_in) begin
          // Abort wins over a same-cycle handshake.
          estado_n   = CAPTURA;
          clr        = 1'b1;
          overflow_n = 1'b0;
          comp_n     = '0;
        end else if (out_valid && out_ready) begin
          pop = 1'b1;
          if (ptr == PTR_WIDTH'(1)) begin
            estado_n = OCIOSO;
          end else begin
            valid_n = 1'b1;
            addr_n  = sob_topo;
            last_n  = (ptr == PTR_WIDTH'(2));
          end
        end else begin
          valid_n = out_valid;
          addr_n  = out_addr;
          last_n  = out_last;
        end
      end

      default: begin
        estado_n = OCIOSO;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado          <= OCIOSO;
      out_valid       <= 1'b0;
      out_addr        <= '0;
      out_last        <= 1'b0;
      comprimento_out <= '0;
      ocupado_out     <= 1'b0;
      overflow_out    <= 1'b0;
    end else begin
      estado          <= estado_n;
      out_valid       <= valid_n;
      out_addr        <= addr_n;
      out_last        <= last_n;
      comprimento_out <= comp_n;
      ocupado_out     <= (estado_n != OCIOSO);
      overflow_out    <= overflow_n;
    end
  end

endmodule

// File: tb/tb_emissor_caminho.sv
// Scoreboard bench for emissor_caminho (MAX_CAMINHO=4 so overflow is reachable).
module tb_emissor_caminho;

  localparam int unsigned AW   = 6;
  localparam int unsigned MAXC = 4;
  localparam int unsigned PW   = $clog2(MAXC + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cap_inicio = 1'b0;
  logic          cap_valid = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic          cap_fim = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic [PW-1:0] comprimento_out;
  logic          ocupado_out;
  logic          overflow_out;

  emissor_caminho #(.ADDR_WIDTH(AW), .MAX_CAMINHO(MAXC)) dut (
    .clk             (clk),
    .rst             (rst),
    .cap_inicio_in   (cap_inicio),
    .cap_valid_in    (cap_valid),
    .cap_addr_in     (cap_addr),
    .cap_fim_in      (cap_fim),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_addr        (out_addr),
    .out_last        (out_last),
    .comprimento_out (comprimento_out),
    .ocupado_out     (ocupado_out),
    .overflow_out    (overflow_out)
  );

  always #5 clk = ~clk;

  beat_t         exp_q[$];
  logic [AW-1:0] caminho[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_beats = 0;
  int            exp_len = 0;
  int            exp_ovf = 0;
  int            rdy_mode = 0;
  int            rdy_cnt = 0;
  int            rdy_last_mode = 0;

  task automatic check(input string nome, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the captured list reversed, or nothing on overflow/empty.
  function automatic void model_fim();
    int n;
    beat_t b;
    n = caminho.size();
    exp_ovf = (n > MAXC) ? 1 : 0;
    exp_len = (exp_ovf == 1) ? 0 : n;
    if (exp_ovf == 0) begin
      for (int i = n - 1; i >= 0; i--) begin
        b.addr = caminho[i];
        b.last = (i == 0);
        exp_q.push_back(b);
      end
    end
  endfunction

  task automatic start_req();
    cap_inicio = 1'b1;
    exp_q.delete();
    tick();
    cap_inicio = 1'b0;
  endtask

  task automatic capture(input bit merge);
    int n;
    n = caminho.size();
    for (int i = 0; i < n; i++) begin
      cap_valid = 1'b1;
      cap_addr  = caminho[i];
      cap_fim   = merge && (i == n - 1);
      if (cap_fim) model_fim();
      tick();
      cap_valid = 1'b0;
      cap_fim   = 1'b0;
      if (!(merge && (i == n - 1))) begin
        repeat ($urandom_range(0, 2)) begin
          cap_addr = AW'($urandom);
          tick();
        end
      end
    end
    if (!merge || n == 0) begin
      cap_fim = 1'b1;
      model_fim();
      tick();
    end
    cap_valid = 1'b0;
    cap_fim   = 1'b0;
  endtask

  // Drains the expected beats while toggling the (ignored) capture inputs.
  task automatic wait_done(input string nome, input int exp_beats, input int beats0);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || ocupado_out) && k < 300) begin
      cap_valid = 1'($urandom);
      cap_fim   = 1'($urandom);
      cap_addr  = AW'($urandom);
      tick();
      k++;
    end
    cap_valid = 1'b0;
    cap_fim   = 1'b0;
    check({nome, "_timeout"}, (k < 300) ? 1 : 0, 1);
    check({nome, "_ocupado"}, int'(ocupado_out), 0);
    check({nome, "_valid_fim"}, int'(out_valid), 0);
    check({nome, "_comprimento"}, int'(comprimento_out), exp_len);
    check({nome, "_overflow"}, int'(overflow_out), exp_ovf);
    if (exp_beats >= 0) check({nome, "_n_beats"}, n_beats - beats0, exp_beats);
  endtask

  task automatic check_zero(input string nome);
    check({nome, "_valid"}, int'(out_valid), 0);
    check({nome, "_addr"}, int'(out_addr), 0);
    check({nome, "_last"}, int'(out_last), 0);
    check({nome, "_comprimento"}, int'(comprimento_out), 0);
    check({nome, "_ocupado"}, int'(ocupado_out), 0);
    check({nome, "_overflow"}, int'(overflow_out), 0);
  endtask

  // Consumer ready: 0 always, 1 random, 2 stall four valid cycles then alternate.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != rdy_last_mode) begin
        rdy_cnt       = 0;
        rdy_last_mode = rdy_mode;
      end
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom);
        default: begin
          if (out_valid) begin
            out_ready = (rdy_cnt < 4) ? 1'b0 : rdy_cnt[0];
            rdy_cnt++;
          end else begin
            out_ready = 1'b0;
          end
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks hold-while-stalled.
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic          prev_last = 1'b0;
  always @(negedge clk) begin
    beat_t b;
    if (!rst && !cap_inicio) begin
      if (exp_q.size() == 0) check("valid_sem_esperado", int'(out_valid), 0);
      if (out_valid) begin
        if (prev_stall) begin
          check("addr_estavel", int'(out_addr), int'(prev_addr));
          check("last_estavel", int'(out_last), int'(prev_last));
        end
        if (out_ready && exp_q.size() != 0) begin
          b = exp_q.pop_front();
          n_beats++;
          check("beat_addr", int'(out_addr), int'(b.addr));
          check("beat_last", int'(out_last), int'(b.last));
        end
      end else begin
        check("addr_zero_sem_valid", int'(out_addr), 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0;
    int k;
    bit merge;
    int n;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Basic path 12,7,3 -> 3,7,12.
    rdy_mode = 0;
    start_req();
    caminho = '{6'd12, 6'd7, 6'd3};
    b0 = n_beats;
    capture(1'b0);
    wait_done("basico", 3, b0);

    // Back-pressure: stall then alternating ready.
    rdy_mode = 2;
    start_req();
    caminho = '{6'd12, 6'd7, 6'd3};
    b0 = n_beats;
    capture(1'b0);
    wait_done("stall", 3, b0);
    rdy_mode = 0;

    // Push and fim in the same cycle.
    start_req();
    caminho = '{6'd9, 6'd5};
    b0 = n_beats;
    capture(1'b1);
    wait_done("push_fim", 2, b0);

    // Overflow: five pushes into a depth-4 stack.
    start_req();
    caminho = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
    b0 = n_beats;
    capture(1'b0);
    wait_done("overflow", 0, b0);

    // Empty path.
    start_req();
    caminho.delete();
    b0 = n_beats;
    capture(1'b0);
    wait_done("vazio", 0, b0);

    // Abort after the first beat, then a new path.
    start_req();
    caminho = '{6'd20, 6'd21, 6'd22};
    b0 = n_beats;
    capture(1'b0);
    k = 0;
    while (n_beats == b0 && k < 50) begin
      tick();
      k++;
    end
    check("abort_primeiro_beat", n_beats - b0, 1);
    start_req();
    check("abort_valid", int'(out_valid), 0);
    check("abort_ocupado", int'(ocupado_out), 1);
    caminho = '{6'd33, 6'd34};
    b0 = n_beats;
    capture(1'b1);
    wait_done("pos_abort", 2, b0);

    // Reset mid-emission.
    rdy_mode = 1;
    start_req();
    caminho = '{6'd40, 6'd41, 6'd42};
    capture(1'b0);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("rst_emite_valid", int'(out_valid), 1);
    exp_q.delete();
    rst = 1'b1;
    tick();
    check_zero("rst_meio");
    tick();
    rst = 1'b0;
    check_zero("rst_fim");
    tick();
    start_req();
    caminho = '{6'd2, 6'd3};
    b0 = n_beats;
    capture(1'b0);
    wait_done("pos_rst", 2, b0);

    // Randomized requests with occasional aborts.
    for (int it = 0; it < 40; it++) begin
      rdy_mode = 1;
      repeat ($urandom_range(0, 2)) begin
        cap_valid = 1'($urandom);
        cap_fim   = 1'($urandom);
        cap_addr  = AW'($urandom);
        tick();
      end
      cap_valid = 1'b0;
      cap_fim   = 1'b0;
      n = $urandom_range(0, MAXC + 1);
      caminho.delete();
      for (int i = 0; i < n; i++) caminho.push_back(AW'($urandom));
      merge = 1'($urandom);
      start_req();
      b0 = n_beats;
      capture(merge);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 6)) tick();
        start_req();
        n = $urandom_range(1, MAXC);
        caminho.delete();
        for (int i = 0; i < n; i++) caminho.push_back(AW'($urandom));
        b0 = n_beats;
        capture(1'b0);
        wait_done("rand_abort", n, b0);
      end else begin
        wait_done("rand", (n > MAXC) ? 0 : n, b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
